// File: rtl/pipeline_stage_memory.sv
// pipeline_stage_memory: memory pipeline stage with stalling data-memory access and a timeout.
// Defining SUBWORD_ACCESS_EN enables byte and halfword accesses; without it, every access is a word access.
package pipeline_stage_memory_pkg;
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;
  localparam logic [4:0] ZERO = 5'd0;
  typedef struct packed {
    logic memReadEnabled;
    logic memWriteEnabled;
    logic [1:0] memWidth;
    logic memSignExtend;
  } mem_signals_t;
  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
  } reg_data_t;
  typedef struct packed {
    logic bubbled;
    logic [4:0] regWriteId;
    logic regWriteEnabled;
    logic [31:0] regDataWrite;
    logic [31:0] aluResult;
    reg_data_t regData;
    mem_signals_t signals;
  } pipeline_result_execuation_t;
  typedef struct packed {
    logic [4:0] regWriteId;
    logic regWriteEnabled;
    logic [31:0] regDataWrite;
    logic bubbled;
  } pipeline_result_memory_t;
  typedef struct packed {
    logic [4:0] registerId;
    logic dataReady;
    logic [31:0] data;
  } stage_register_data_t;
endpackage

module pipeline_stage_memory
  import pipeline_stage_memory_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  pipeline_result_execuation_t pipelineResultExecuation,
  output logic                        memReq,
  output logic                        memWrite,
  output logic [31:0]                 memAddr,
  output logic [31:0]                 memWriteData,
  output logic [3:0]                  memByteEnable,
  input  logic                        memReady,
  input  logic [31:0]                 memReadData,
  output pipeline_result_memory_t     pipelineResultMemory,
  output stage_register_data_t        resultOfInstructionAfterMemory,
  output logic                        stallFromMemory,
  output logic                        memError
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_next;
  pipeline_result_execuation_t x;
  logic [15:0] count;
  logic mem_op, timeout, unused;
  logic [31:0] acc_addr, acc_wdata, load_data;
  logic [3:0] acc_be;
  assign x = pipelineResultExecuation;
  assign mem_op = !x.bubbled && (x.signals.memReadEnabled || x.signals.memWriteEnabled);
  assign timeout = count == 16'(TIMEOUT_CYCLES - 1);
`ifdef SUBWORD_ACCESS_EN
  logic [31:0] byte_lane, half_lane;
  assign unused = ^x.regData.data1;
  assign byte_lane = memReadData >> {memAddr[1:0], 3'b000};
  assign half_lane = memReadData >> {memAddr[1], 4'b0000};
  always_comb begin
    acc_addr = x.aluResult;
    acc_be = 4'b1111;
    acc_wdata = x.regData.data2;
    if (x.signals.memWidth == MEM_BYTE) begin
      acc_be = 4'b0001 << x.aluResult[1:0];
      acc_wdata = {4{x.regData.data2[7:0]}};
    end else if (x.signals.memWidth == MEM_HALF) begin
      acc_be = 4'b0011 << {x.aluResult[1], 1'b0};
      acc_wdata = {2{x.regData.data2[15:0]}};
    end else
      acc_addr[1:0] = 2'b00;
  end
  always_comb begin
    load_data = memReadData;
    if (x.signals.memWidth == MEM_BYTE)
      load_data = {{24{x.signals.memSignExtend && byte_lane[7]}}, byte_lane[7:0]};
    else if (x.signals.memWidth == MEM_HALF)
      load_data = {{16{x.signals.memSignExtend && half_lane[15]}}, half_lane[15:0]};
  end
`else
  assign unused = ^{x.regData.data1, x.aluResult[1:0], x.signals.memWidth, x.signals.memSignExtend};
  assign acc_addr = {x.aluResult[31:2], 2'b00};
  assign acc_be = 4'b1111;
  assign acc_wdata = x.regData.data2;
  assign load_data = memReadData;
`endif
  always_comb begin
    state_next = state;
    stallFromMemory = 1'b0;
    if (state == IDLE) begin
      stallFromMemory = mem_op;
      state_next = mem_op ? WAIT : IDLE;
    end else begin
      stallFromMemory = !memReady && !timeout;
      state_next = (memReady || timeout) ? IDLE : WAIT;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      memReq <= 1'b0;
      memWrite <= 1'b0;
      memAddr <= '0;
      memWriteData <= '0;
      memByteEnable <= '0;
      count <= '0;
      memError <= 1'b0;
      pipelineResultMemory <= '{bubbled: 1'b1, default: '0};
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        pipelineResultMemory <= '{regWriteId: x.regWriteId, regWriteEnabled: x.regWriteEnabled,
                                  regDataWrite: x.regDataWrite, bubbled: x.bubbled || mem_op};
        if (mem_op) begin
          memReq <= 1'b1;
          memWrite <= x.signals.memWriteEnabled;
          memAddr <= acc_addr;
          memWriteData <= acc_wdata;
          memByteEnable <= acc_be;
          count <= '0;
        end
      end else if (memReady) begin
        memReq <= 1'b0;
        pipelineResultMemory <= '{regWriteId: x.regWriteId, regWriteEnabled: x.regWriteEnabled,
                                  regDataWrite: memWrite ? x.regDataWrite : load_data, bubbled: 1'b0};
      end else if (timeout) begin
        memReq <= 1'b0;
        memError <= 1'b1;
      end else
        count <= count + 16'd1;
    end
  end
  assign resultOfInstructionAfterMemory = pipelineResultMemory.bubbled
    ? stage_register_data_t'{registerId: ZERO, dataReady: 1'b1, data: '0}
    : stage_register_data_t'{registerId: pipelineResultMemory.regWriteEnabled ? pipelineResultMemory.regWriteId : ZERO,
                             dataReady: 1'b1, data: pipelineResultMemory.regDataWrite};
endmodule

// File: tb/tb_pipeline_stage_memory.sv
// tb_pipeline_stage_memory: vector table, directed corner sequences and a randomized transaction-level model.
module tb_pipeline_stage_memory;
  import pipeline_stage_memory_pkg::*;
  localparam int TO = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  pipeline_result_execuation_t pe, bubble_in, x;
  logic memReq, memWrite, memReady, stallFromMemory, memError;
  logic [31:0] memAddr, memWriteData, memReadData;
  logic [3:0] memByteEnable;
  pipeline_result_memory_t prm;
  stage_register_data_t fwd;
  int total = 0, bad = 0;
  int n_stall, n_req;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0] cap_be;
  logic cap_write, timed_out, err;

  pipeline_stage_memory #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .pipelineResultExecuation(pe),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWriteData(memWriteData),
    .memByteEnable(memByteEnable), .memReady(memReady), .memReadData(memReadData),
    .pipelineResultMemory(prm), .resultOfInstructionAfterMemory(fwd),
    .stallFromMemory(stallFromMemory), .memError(memError)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 bubble (carrying a load flag that must be ignored)
  function automatic pipeline_result_execuation_t mk(input int kind, input logic [4:0] id, input logic [31:0] data,
      input logic [31:0] addr, input logic [31:0] d2, input logic [1:0] width, input logic sx);
    mk = '0;
    mk.bubbled = kind == 3;
    mk.regWriteId = id;
    mk.regWriteEnabled = kind != 2;
    mk.regDataWrite = data;
    mk.aluResult = addr;
    mk.regData.data1 = 32'h1111_2222;
    mk.regData.data2 = d2;
    mk.signals.memReadEnabled = kind == 1 || kind == 3;
    mk.signals.memWriteEnabled = kind == 2;
    mk.signals.memWidth = width;
    mk.signals.memSignExtend = sx;
  endfunction

  // Holds x until the stage stops stalling; memReady fires in WAIT cycle number lat.
  task automatic issue(input pipeline_result_execuation_t xi, input int lat, input logic [31:0] rd);
    int w;
    logic s, seen;
    w = 0; seen = 0; n_stall = 0; n_req = 0; timed_out = 1;
    pe = xi;
    memReadData = rd;
    for (int c = 0; c < 40; c++) begin
      if (memReq) begin
        w++; n_req++;
        if (!seen) begin
          cap_addr = memAddr; cap_wdata = memWriteData; cap_be = memByteEnable; cap_write = memWrite; seen = 1;
        end
      end
      memReady = memReq ? (w == lat) : 1'($urandom_range(0, 1));
      #1 s = stallFromMemory;
      if (s) n_stall++;
      @(negedge clock);
      if (!s) begin
        timed_out = 0;
        break;
      end
    end
    pe = bubble_in;
    memReady = 1'b0;
    #1;
    chk("completed", 32'(timed_out), 32'd0);
  endtask

  typedef struct {
    logic [4:0] id; logic we; logic [31:0] data; logic bub;
    logic [31:0] exp_data; logic [4:0] exp_fid; logic exp_bub;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{5'd5, 1'b1, 32'h0000_1234, 1'b0, 32'h0000_1234, 5'd5, 1'b0};
    tbl[1] = '{5'd7, 1'b0, 32'hAAAA_5555, 1'b0, 32'hAAAA_5555, 5'd0, 1'b0};
    tbl[2] = '{5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0};
    tbl[3] = '{5'd9, 1'b1, 32'h0000_0055, 1'b1, 32'h0000_0000, 5'd0, 1'b1};
    tbl[4] = '{5'd0, 1'b1, 32'h0000_0077, 1'b0, 32'h0000_0077, 5'd0, 1'b0};
    bubble_in = mk(3, 5'd0, 32'd0, 32'd0, 32'd0, MEM_WORD, 1'b0);
    pe = bubble_in;
    memReady = 1'b0;
    memReadData = '0;
    err = 0;
    #12;
    chk("rst memReq", 32'(memReq), 0);
    chk("rst memAddr", memAddr, 0);
    chk("rst memWriteData", memWriteData, 0);
    chk("rst memByteEnable", 32'(memByteEnable), 0);
    chk("rst memError", 32'(memError), 0);
    chk("rst bubbled", 32'(prm.bubbled), 1);
    chk("rst regDataWrite", prm.regDataWrite, 0);
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl[i]) begin
      x = mk(0, tbl[i].id, tbl[i].data, 32'h40, 32'h0, MEM_WORD, 1'b0);
      x.regWriteEnabled = tbl[i].we;
      x.bubbled = tbl[i].bub;
      x.signals.memReadEnabled = tbl[i].bub;
      issue(x, 1, 32'h0);
      chk($sformatf("vec%0d stalls", i), n_stall, 0);
      chk($sformatf("vec%0d memReq cycles", i), n_req, 0);
      chk($sformatf("vec%0d bubbled", i), 32'(prm.bubbled), 32'(tbl[i].exp_bub));
      chk($sformatf("vec%0d fwd id", i), 32'(fwd.registerId), 32'(tbl[i].exp_fid));
      chk($sformatf("vec%0d fwd data", i), fwd.data, tbl[i].exp_data);
      chk($sformatf("vec%0d fwd ready", i), 32'(fwd.dataReady), 1);
    end

    issue(mk(1, 5'd3, 32'h0, 32'h100, 32'h0, MEM_WORD, 1'b0), 4, 32'hDEAD_BEEF);
    chk("lw stalls", n_stall, 4);
    chk("lw req cycles", n_req, 4);
    chk("lw addr", cap_addr, 32'h100);
    chk("lw be", 32'(cap_be), 32'hF);
    chk("lw write", 32'(cap_write), 0);
    chk("lw data", prm.regDataWrite, 32'hDEAD_BEEF);
    chk("lw bubbled", 32'(prm.bubbled), 0);
    chk("lw fwd", {fwd.registerId, fwd.dataReady}, {5'd3, 1'b1});
    chk("lw memReq after", 32'(memReq), 0);

    issue(mk(2, 5'd8, 32'h5A5A, 32'h203, 32'hCAFE_BABE, MEM_WORD, 1'b0), 2, 32'h0BAD_0BAD);
    chk("sw stalls", n_stall, 2);
    chk("sw addr", cap_addr, 32'h200);
    chk("sw wdata", cap_wdata, 32'hCAFE_BABE);
    chk("sw be", 32'(cap_be), 32'hF);
    chk("sw write", 32'(cap_write), 1);
    chk("sw data", prm.regDataWrite, 32'h5A5A);
    chk("sw fwd id", 32'(fwd.registerId), 0);

`ifdef SUBWORD_ACCESS_EN
    issue(mk(1, 5'd4, 32'h0, 32'h103, 32'h0, MEM_BYTE, 1'b1), 1, 32'h80FF_FFFF);
    chk("lb be", 32'(cap_be), 32'h8);
    chk("lb signed", prm.regDataWrite, 32'hFFFF_FF80);
    issue(mk(1, 5'd4, 32'h0, 32'h103, 32'h0, MEM_BYTE, 1'b0), 1, 32'h80FF_FFFF);
    chk("lbu unsigned", prm.regDataWrite, 32'h0000_0080);
    issue(mk(1, 5'd6, 32'h0, 32'h102, 32'h0, MEM_HALF, 1'b0), 2, 32'h80FF_1234);
    chk("lhu be", 32'(cap_be), 32'hC);
    chk("lhu data", prm.regDataWrite, 32'h0000_80FF);
    issue(mk(2, 5'd0, 32'h0, 32'h101, 32'h0000_00AB, MEM_BYTE, 1'b0), 1, 32'h0);
    chk("sb be", 32'(cap_be), 32'h2);
    chk("sb wdata", cap_wdata, 32'hABAB_ABAB);
`else
    issue(mk(1, 5'd4, 32'h0, 32'h103, 32'h0, MEM_BYTE, 1'b1), 1, 32'h80FF_FFFF);
    chk("lb-as-word be", 32'(cap_be), 32'hF);
    chk("lb-as-word addr", cap_addr, 32'h100);
    chk("lb-as-word data", prm.regDataWrite, 32'h80FF_FFFF);
`endif

    issue(mk(1, 5'd10, 32'h0, 32'h400, 32'h0, MEM_WORD, 1'b0), 100, 32'h0);
    chk("to req cycles", n_req, TO);
    chk("to stalls", n_stall, TO);
    chk("to bubbled", 32'(prm.bubbled), 1);
    chk("to memError", 32'(memError), 1);
    chk("to memReq", 32'(memReq), 0);
    issue(mk(0, 5'd2, 32'h99, 32'h0, 32'h0, MEM_WORD, 1'b0), 1, 32'h0);
    chk("memError sticky", 32'(memError), 1);
    chk("after to data", prm.regDataWrite, 32'h99);

    pe = mk(1, 5'd12, 32'h0, 32'h300, 32'h0, MEM_WORD, 1'b0);
    memReady = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("pre-reset memReq", 32'(memReq), 1);
    #2 reset = 1'b1;
    #1;
    chk("async rst memReq", 32'(memReq), 0);
    chk("async rst memAddr", memAddr, 0);
    chk("async rst bubbled", 32'(prm.bubbled), 1);
    chk("async rst memError", 32'(memError), 0);
    err = 0;
    pe = bubble_in;
    @(negedge clock);
    reset = 1'b0;
    memReady = 1'b1;
    memReadData = 32'h1234_5678;
    @(negedge clock);
    @(negedge clock);
    memReady = 1'b0;
    #1;
    chk("late ready memReq", 32'(memReq), 0);
    chk("late ready bubbled", 32'(prm.bubbled), 1);
    chk("late ready fwd data", fwd.data, 0);

    for (int t = 0; t < 200; t++) begin
      int kind, lat;
      logic [31:0] addr, rd, data, d2, exp_data;
      logic [4:0] id;
      logic mem, exp_bub;
      kind = $urandom_range(0, 3);
      lat = $urandom_range(1, TO + 2);
      addr = $urandom; rd = $urandom; data = $urandom; d2 = $urandom;
      id = 5'($urandom);
      mem = kind == 1 || kind == 2;
      issue(mk(kind, id, data, addr, d2, MEM_WORD, 1'($urandom)), lat, rd);
      exp_bub = kind == 3 || (mem && lat > TO);
      exp_data = exp_bub ? 32'd0 : (kind == 1 ? rd : data);
      if (mem && lat > TO) err = 1;
      chk("rnd stalls", n_stall, mem ? (lat > TO ? TO : lat) : 0);
      chk("rnd req cycles", n_req, mem ? (lat > TO ? TO : lat) : 0);
      chk("rnd bubbled", 32'(prm.bubbled), 32'(exp_bub));
      chk("rnd fwd data", fwd.data, exp_data);
      chk("rnd fwd id", 32'(fwd.registerId), (exp_bub || kind == 2) ? 0 : 32'(id));
      chk("rnd memError", 32'(memError), 32'(err));
      if (mem) begin
        chk("rnd addr", cap_addr, {addr[31:2], 2'b00});
        chk("rnd write", 32'(cap_write), 32'(kind == 2));
        chk("rnd be", 32'(cap_be), 32'hF);
        if (kind == 2) chk("rnd wdata", cap_wdata, d2);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_memory.md
PIPELINE_STAGE_MEMORY -- requirements
Module: pipeline_stage_memory

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum WAIT cycles before an access is aborted (1..65535).
REQ-002 Port: clock  input  1  sole clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-004 Port: pipelineResultExecuation  input  pipeline_result_execuation_t  packed result from the execution stage, held stable by upstream while stallFromMemory=1.
REQ-005 Port: memReq  output  1  registered; high for the whole data-memory access.
REQ-006 Port: memWrite  output  1  registered; 1 = store, 0 = load; valid while memReq=1.
REQ-007 Port: memAddr  output  32  registered access address, taken from aluResult.
REQ-008 Port: memWriteData  output  32  registered store data, from regData.data2, lane-shifted per REQ-017.
REQ-009 Port: memByteEnable  output  4  registered byte lanes.
REQ-010 Port: memReady  input  1  responder completion strobe; sampled only in WAIT.
REQ-011 Port: memReadData  input  32  load data; valid in the cycle memReady=1.
REQ-012 Port: pipelineResultMemory  output  struct (regWriteId, regWriteEnabled, regDataWrite, bubbled)  registered result to write-back.
REQ-013 Port: resultOfInstructionAfterMemory  output  stage_register_data_t  forwarding info for hazard units.
REQ-014 Port: stallFromMemory  output  1  combinational; upstream holds its instruction while high.
REQ-015 Port: memError  output  1  sticky timeout flag.

Function
REQ-016 States: IDLE, WAIT; "mem op" = input not bubbled and signals.memReadEnabled or signals.memWriteEnabled.
- IDLE, no mem op: load pipelineResultMemory from the input. regDataWrite = input regDataWrite. Latency 1 cycle; stall 0.
- IDLE, mem op: stallFromMemory=1. Register memReq=1 with memWrite, memAddr, memWriteData and memByteEnable. Go to WAIT. Output bubbled=1. Timeout counter clears to 0.
- WAIT, memReady=0: stallFromMemory=1 and counter increments. At counter==TIMEOUT_CYCLES-1: memReq<=0, memError<=1, output bubbled=1, state<=IDLE, stall 0 (instruction dropped).
- WAIT, memReady=1: stallFromMemory=0 (instruction consumed). memReq<=0, state<=IDLE. Output takes the instruction; regDataWrite = extended memReadData for loads, the input regDataWrite for stores.
- Total load latency: 1 + N cycles, where N>=1 is the number of WAIT cycles up to and including memReady.
REQ-017 Lanes: word access uses memByteEnable=1111 and memAddr[1:0]=00. Sub-word lanes per Configuration.
REQ-018 Bubbled input in IDLE: output bubbled=1, no memory activity, stall 0.
REQ-019 Forwarding output: if the output is bubbled, drive {ZERO, dataReady=1, data=0}. Otherwise drive {regWriteId, 1, regDataWrite}. If regWriteEnabled=0, drive registerId ZERO.
REQ-020 Back-to-back mem ops: after WAIT->IDLE, a new mem op may launch in the following cycle. memReq deasserts for at least 1 cycle between accesses.
REQ-021 memReady outside WAIT is ignored.

Reset
REQ-022 While reset=1, all of the following hold: state=IDLE, memReq=0, memWrite=0, memAddr=0, memWriteData=0, memByteEnable=0, counter=0, memError=0, pipelineResultMemory.bubbled=1, other output fields=0.
REQ-023 Reset during WAIT drops memReq in the same cycle and discards the access; a late memReady is ignored.

Configuration
REQ-024 SUBWORD_ACCESS_EN defined: signals.memWidth selects the access size (byte/half/word) and signals.memSignExtend selects the load extension.
- Byte: enable 0001<<addr[1:0], store data replicated to all 4 bytes.
- Half: enable 0011<<(addr[1]*2), store data replicated to both halves.
- Loads are extracted from the selected lane, then sign- or zero-extended to 32 bits.
- Undefined: every access is word per REQ-017 and memWidth/memSignExtend are ignored.

Verification
REQ-025 Non-mem ALU op writing r5=0x1234, not bubbled -> next cycle output regDataWrite=0x1234, forwarding {r5,1,0x1234}, stall never asserted.
REQ-026 Load word from addr 0x100, memReady 3 cycles after memReq, memReadData=0xDEADBEEF -> stall high for 4 cycles; memAddr=0x100, memByteEnable=1111; output 0xDEADBEEF one cycle after memReady.
REQ-027 With SUBWORD_ACCESS_EN: signed byte load at 0x103, memReadData=0x80FFFFFF -> regDataWrite=0xFFFFFF80, memByteEnable=1000. Same stimulus, unsigned -> 0x00000080.
REQ-028 TIMEOUT_CYCLES=4, memReady never asserted -> memReq drops after 4 WAIT cycles, memError=1 sticky, output bubbled, stall releases.
REQ-029 Assert reset during WAIT, then memReady after release -> memReq=0 immediately, outputs match REQ-022, late memReady produces no output.
